shift_issue: RTL and testbench
==============================

# shift_issue

Execute-stage issue register sitting directly upstream of the combinational `shift` unit. It decodes R-type shift `funct` codes into the shifter's 2-bit `op` and selects the operand sources: `rt` is the shifted value, and the amount comes from `shamt` or `rs[4:0]`. It resolves register hazards by forwarding from the MEM and WB stages. It registers the result behind a valid/ready handshake with a one-entry skid buffer, so back-pressure from downstream never drops an instruction.

## Interface
- No parameters; widths are fixed at 32-bit data and 5-bit register addresses.
- `clk` input 1: single clock, rising edge.
- `reset` input 1: synchronous, active-high.
- `flush` input 1: discard all held and incoming instructions.
- `in_valid` input 1: upstream presents an instruction.
- `in_ready` output 1: block can accept this cycle.
- `funct` input 6: R-type function field.
- `shamt` input 5: immediate shift amount.
- `rs_addr`, `rt_addr` input 5 each: source register numbers.
- `rs_val`, `rt_val` input 32 each: register-file read data.
- `mem_wen`, `wb_wen` input 1 each: MEM/WB stage will write a register.
- `mem_waddr`, `wb_waddr` input 5 each: destination register numbers.
- `mem_wdata`, `wb_wdata` input 32 each: values being written.
- `out_valid` output 1: `op`/`a`/`b` are valid for the shifter.
- `out_ready` input 1: downstream consumes this cycle.
- `op` output 2: to the shifter.
- `a`, `b` output 32 each: to the shifter.
- `illegal` output 1: the current output carries an undecodable `funct`.

## Operation
- Decode of `funct` to `op` and `b`:
  - 6'h00 sll: op 00, b = {27'b0, shamt}.
  - 6'h02 srl: op 01, b = {27'b0, shamt}.
  - 6'h03 sra: op 11, b = {27'b0, shamt}.
  - 6'h04 sllv: op 00, b = forwarded rs.
  - 6'h06 srlv: op 01, b = forwarded rs.
  - 6'h07 srav: op 11, b = forwarded rs.
  - Any other value: op 10 (pass-through), b = 0, illegal = 1.
- `a` is always the forwarded `rt`.
- Forwarding, evaluated per source at the accept cycle:
  - Register address 0 always yields 0.
  - Otherwise, a MEM match (`mem_wen` and `mem_waddr` == addr) wins.
  - Otherwise, a WB match wins.
  - Otherwise, the register-file value is used.
- Storage is one output register plus one skid register, each holding fully resolved {op, a, b, illegal}.
- Accept happens when `in_valid && in_ready`.
  - Output empty, or output draining this cycle: the new entry goes to the output register.
  - Output full and stalled (`out_valid && !out_ready`): the new entry goes to the skid register.
- Drain happens when `out_valid && out_ready`.
  - If skid is full, skid moves to output and skid is cleared.
  - Else, if an accept occurs in the same cycle, the new entry is loaded.
  - Else, `out_valid` drops to 0.
- `in_ready` = !skid_valid, taken directly from a register.
- Ordering is strictly FIFO; no instruction is duplicated or lost.
- `flush` clears `out_valid` and `skid_valid` on the next edge.
  - An instruction presented in the same cycle is dropped.
  - `flush` overrides any accept or drain in that cycle.
- `reset` behaves like `flush` and additionally zeroes the data registers.

## Timing
- Reset values: `out_valid` 0, `op` 00, `a` 0, `b` 0, `illegal` 0; `in_ready` 1 (skid empty).
- Latency is 1 cycle: an accept at edge N makes the output visible after edge N.
- With `out_ready` held high, throughput is 1 instruction per cycle.
- `in_ready` falls one cycle after the first stalled accept, and rises the cycle after the skid drains.
- Output data stays stable while `out_valid && !out_ready`.
- Forwarding inputs are sampled only at the accept edge. Later MEM/WB changes do not alter held entries.
- No combinational path exists from `out_ready` to `in_ready`.

## Configuration
- `SHIFT_ISSUE_FWD_EN` defined: MEM/WB forwarding as described above.
- Undefined: `a` = `rt_val` and variable `b` = `rs_val` directly. The `mem_*`/`wb_*` ports remain but are ignored. The register-0 zeroing rule still applies.

## Test plan
- Reset then idle: all outputs at their reset values.
- sra: accept funct 03, shamt 4, rt_val 32'h8000_0000 → next cycle out_valid 1, op 11, a 32'h8000_0000, b 4.
- Forwarding: srlv with rs_addr 5, rs_val 1, mem_wen 1, mem_waddr 5, mem_wdata 8, wb_wen 1, wb_waddr 5, wb_wdata 9 → b 8. With rs_addr 0 under the same inputs → b 0.
- Back-pressure: out_ready 0, accept instructions A, B.
  - Expected: in_ready 0 after B.
  - Raise out_ready: A then B emerge in consecutive cycles, and in_ready returns to 1.
- Illegal: funct 6'h20 → op 10, b 0, illegal 1.
- Flush with full output and skid plus a valid input → next cycle out_valid 0, in_ready 1, and no later emission of any of the three instructions.

Source files
------------

// File: rtl/shift_issue.sv
// Execute-stage issue register feeding the combinational shifter: decodes shift funct codes,
// resolves sources and holds results behind a valid/ready handshake with a one-entry skid buffer.
// Optional MEM/WB forwarding is compiled in with `define SHIFT_ISSUE_FWD_EN.
module shift_issue (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [5:0]  funct,
  input  logic [4:0]  shamt,
  input  logic [4:0]  rs_addr,
  input  logic [4:0]  rt_addr,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        mem_wen,
  input  logic        wb_wen,
  input  logic [4:0]  mem_waddr,
  input  logic [4:0]  wb_waddr,
  input  logic [31:0] mem_wdata,
  input  logic [31:0] wb_wdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [1:0]  op,
  output logic [31:0] a,
  output logic [31:0] b,
  output logic        illegal
);

  localparam int DATA_W = 32;

  logic [DATA_W-1:0] rs_fwd_p0, rt_fwd_p0;
  logic [1:0]        op_p0;
  logic [DATA_W-1:0] a_p0, b_p0;
  logic              ill_p0;

  logic              vld_p1, sk_vld_p1;
  logic [1:0]        op_p1, sk_op_p1;
  logic [DATA_W-1:0] a_p1, b_p1, sk_a_p1, sk_b_p1;
  logic              ill_p1, sk_ill_p1;

  logic accept, drain;

`ifdef SHIFT_ISSUE_FWD_EN
  // The younger MEM result takes priority over WB.
  function automatic logic [DATA_W-1:0] fwd_sel(
    input logic [4:0]        addr,
    input logic [DATA_W-1:0] rf,
    input logic              m_wen,
    input logic [4:0]        m_waddr,
    input logic [DATA_W-1:0] m_wdata,
    input logic              w_wen,
    input logic [4:0]        w_waddr,
    input logic [DATA_W-1:0] w_wdata
  );
    if (m_wen && (m_waddr == addr)) return m_wdata;
    if (w_wen && (w_waddr == addr)) return w_wdata;
    return rf;
  endfunction
`else
  logic unused_fwd;
  assign unused_fwd = ^{mem_wen, wb_wen, mem_waddr, wb_waddr, mem_wdata, wb_wdata};
`endif

  // Stage p0: operand resolution and decode at the accept cycle
  always_comb begin
    rs_fwd_p0 = rs_val;
    rt_fwd_p0 = rt_val;
`ifdef SHIFT_ISSUE_FWD_EN
    rs_fwd_p0 = fwd_sel(rs_addr, rs_val, mem_wen, mem_waddr, mem_wdata, wb_wen, wb_waddr, wb_wdata);
    rt_fwd_p0 = fwd_sel(rt_addr, rt_val, mem_wen, mem_waddr, mem_wdata, wb_wen, wb_waddr, wb_wdata);
`endif
    if (rs_addr == 5'd0) rs_fwd_p0 = '0;
    if (rt_addr == 5'd0) rt_fwd_p0 = '0;
  end

  always_comb begin
    op_p0  = 2'b10;
    a_p0   = rt_fwd_p0;
    b_p0   = '0;
    ill_p0 = 1'b0;
    case (funct)
      6'h00: begin op_p0 = 2'b00; b_p0 = {27'b0, shamt}; end
      6'h02: begin op_p0 = 2'b01; b_p0 = {27'b0, shamt}; end
      6'h03: begin op_p0 = 2'b11; b_p0 = {27'b0, shamt}; end
      6'h04: begin op_p0 = 2'b00; b_p0 = rs_fwd_p0; end
      6'h06: begin op_p0 = 2'b01; b_p0 = rs_fwd_p0; end
      6'h07: begin op_p0 = 2'b11; b_p0 = rs_fwd_p0; end
      default: ill_p0 = 1'b1;
    endcase
  end

  assign accept = in_valid && in_ready;
  assign drain  = vld_p1 && out_ready;

  // Stage p1: output register plus skid; skid only fills while the output is stalled
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1    <= 1'b0;
      sk_vld_p1 <= 1'b0;
      op_p1     <= '0;
      a_p1      <= '0;
      b_p1      <= '0;
      ill_p1    <= 1'b0;
      sk_op_p1  <= '0;
      sk_a_p1   <= '0;
      sk_b_p1   <= '0;
      sk_ill_p1 <= 1'b0;
    end else if (flush) begin
      vld_p1    <= 1'b0;
      sk_vld_p1 <= 1'b0;
    end else if (drain) begin
      if (sk_vld_p1) begin
        op_p1     <= sk_op_p1;
        a_p1      <= sk_a_p1;
        b_p1      <= sk_b_p1;
        ill_p1    <= sk_ill_p1;
        sk_vld_p1 <= 1'b0;
      end else if (accept) begin
        op_p1  <= op_p0;
        a_p1   <= a_p0;
        b_p1   <= b_p0;
        ill_p1 <= ill_p0;
      end else begin
        vld_p1 <= 1'b0;
      end
    end else if (accept) begin
      if (!vld_p1) begin
        op_p1  <= op_p0;
        a_p1   <= a_p0;
        b_p1   <= b_p0;
        ill_p1 <= ill_p0;
        vld_p1 <= 1'b1;
      end else begin
        sk_op_p1  <= op_p0;
        sk_a_p1   <= a_p0;
        sk_b_p1   <= b_p0;
        sk_ill_p1 <= ill_p0;
        sk_vld_p1 <= 1'b1;
      end
    end
  end

  assign in_ready  = !sk_vld_p1;
  assign out_valid = vld_p1;
  assign op        = op_p1;
  assign a         = a_p1;
  assign b         = b_p1;
  assign illegal   = ill_p1;

endmodule

// File: tb/tb_shift_issue.sv
// Self-checking bench for shift_issue: directed scenarios plus random traffic against a FIFO
// reference model of the issue register.
module tb_shift_issue;

`ifdef SHIFT_ISSUE_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, in_ready;
  logic [5:0]  funct;
  logic [4:0]  shamt, rs_addr, rt_addr;
  logic [31:0] rs_val, rt_val;
  logic        mem_wen, wb_wen;
  logic [4:0]  mem_waddr, wb_waddr;
  logic [31:0] mem_wdata, wb_wdata;
  logic        out_valid, out_ready;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic        illegal;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        ill;
  } ent_t;

  ent_t q[$];

  always #5 clk = ~clk;

  shift_issue dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .funct(funct), .shamt(shamt), .rs_addr(rs_addr), .rt_addr(rt_addr),
    .rs_val(rs_val), .rt_val(rt_val), .mem_wen(mem_wen), .wb_wen(wb_wen),
    .mem_waddr(mem_waddr), .wb_waddr(wb_waddr), .mem_wdata(mem_wdata), .wb_wdata(wb_wdata),
    .out_valid(out_valid), .out_ready(out_ready), .op(op), .a(a), .b(b), .illegal(illegal)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Value a source register reads as, seen at the accept cycle.
  function automatic logic [31:0] src_value(input logic [4:0] ad, input logic [31:0] rf);
    if (ad == 5'd0) return 32'd0;
    if (FWD && mem_wen && mem_waddr == ad) return mem_wdata;
    if (FWD && wb_wen && wb_waddr == ad) return wb_wdata;
    return rf;
  endfunction

  function automatic ent_t model_entry();
    ent_t e;
    logic [31:0] rs_v;
    rs_v  = src_value(rs_addr, rs_val);
    e.a   = src_value(rt_addr, rt_val);
    e.ill = 1'b0;
    case (funct)
      6'h00: begin e.op = 2'd0; e.b = 32'(shamt); end
      6'h02: begin e.op = 2'd1; e.b = 32'(shamt); end
      6'h03: begin e.op = 2'd3; e.b = 32'(shamt); end
      6'h04: begin e.op = 2'd0; e.b = rs_v; end
      6'h06: begin e.op = 2'd1; e.b = rs_v; end
      6'h07: begin e.op = 2'd3; e.b = rs_v; end
      default: begin e.op = 2'd2; e.b = 32'd0; e.ill = 1'b1; end
    endcase
    return e;
  endfunction

  task automatic check_outputs(input string tag);
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(q.size() > 0));
    chk({tag, ".in_ready"}, 32'(in_ready), 32'(q.size() < 2));
    if (q.size() > 0) begin
      chk({tag, ".op"}, 32'(op), 32'(q[0].op));
      chk({tag, ".a"}, a, q[0].a);
      chk({tag, ".b"}, b, q[0].b);
      chk({tag, ".illegal"}, 32'(illegal), 32'(q[0].ill));
    end
  endtask

  // One clock: advance the model with the inputs present at the edge, then check.
  task automatic step(input string tag);
    ent_t e;
    bit   rdy, drn;
    e   = model_entry();
    rdy = (q.size() < 2);
    drn = (q.size() > 0) && out_ready;
    @(posedge clk);
    if (reset || flush) q.delete();
    else begin
      if (drn) void'(q.pop_front());
      if (in_valid && rdy) q.push_back(e);
    end
    #1;
    check_outputs(tag);
  endtask

  task automatic set_instr(input logic [5:0] f, input logic [4:0] sh, input logic [4:0] rsa,
                           input logic [4:0] rta, input logic [31:0] rsv, input logic [31:0] rtv);
    funct = f; shamt = sh; rs_addr = rsa; rt_addr = rta; rs_val = rsv; rt_val = rtv;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    set_instr(6'h00, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0);
    mem_wen = 1'b0; wb_wen = 1'b0; mem_waddr = '0; wb_waddr = '0; mem_wdata = '0; wb_wdata = '0;

    step("reset0");
    step("reset1");
    reset = 1'b0;
    step("idle");
    chk("rst_op", 32'(op), 32'd0);
    chk("rst_a", a, 32'd0);
    chk("rst_b", b, 32'd0);
    chk("rst_illegal", 32'(illegal), 32'd0);

    // sra by immediate
    in_valid = 1'b1;
    set_instr(6'h03, 5'd4, 5'd2, 5'd3, 32'h1234, 32'h8000_0000);
    step("sra");
    in_valid = 1'b0;
    chk("sra_valid", 32'(out_valid), 32'd1);
    chk("sra_op", 32'(op), 32'd3);
    chk("sra_a", a, 32'h8000_0000);
    chk("sra_b", b, 32'd4);
    step("sra_drain");

    // variable shift with both MEM and WB targeting rs
    in_valid = 1'b1;
    mem_wen = 1'b1; mem_waddr = 5'd5; mem_wdata = 32'd8;
    wb_wen = 1'b1; wb_waddr = 5'd5; wb_wdata = 32'd9;
    set_instr(6'h06, 5'd0, 5'd5, 5'd6, 32'd1, 32'h55);
    step("fwd_mem");
    chk("fwd_mem_b", b, FWD ? 32'd8 : 32'd1);
    rs_addr = 5'd0;
    step("fwd_r0");
    chk("fwd_r0_b", b, 32'd0);
    in_valid = 1'b0; mem_wen = 1'b0; wb_wen = 1'b0;
    step("fwd_drain");

    // back-pressure: A and B stack up, then drain in order
    out_ready = 1'b0;
    in_valid = 1'b1;
    set_instr(6'h00, 5'd1, 5'd0, 5'd7, 32'd0, 32'hAAAA_0001);
    step("bp_a");
    set_instr(6'h02, 5'd2, 5'd0, 5'd8, 32'd0, 32'hBBBB_0002);
    step("bp_b");
    chk("bp_in_ready_low", 32'(in_ready), 32'd0);
    set_instr(6'h07, 5'd3, 5'd0, 5'd9, 32'd0, 32'hCCCC_0003);
    step("bp_blocked");
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("bp_hold_a", a, 32'hAAAA_0001);
    step("bp_drain_a");
    chk("bp_emit_b", a, 32'hBBBB_0002);
    chk("bp_in_ready_high", 32'(in_ready), 32'd1);
    step("bp_drain_b");

    // illegal funct
    in_valid = 1'b1;
    set_instr(6'h20, 5'd9, 5'd1, 5'd2, 32'h77, 32'h66);
    step("illegal");
    chk("illegal_op", 32'(op), 32'd2);
    chk("illegal_b", b, 32'd0);
    chk("illegal_flag", 32'(illegal), 32'd1);
    in_valid = 1'b0;
    step("illegal_drain");

    // flush with output, skid and input all occupied
    out_ready = 1'b0;
    in_valid = 1'b1;
    set_instr(6'h00, 5'd1, 5'd0, 5'd1, 32'd0, 32'h1);
    step("fl_a");
    set_instr(6'h02, 5'd2, 5'd0, 5'd2, 32'd0, 32'h2);
    step("fl_b");
    set_instr(6'h03, 5'd3, 5'd0, 5'd3, 32'd0, 32'h3);
    flush = 1'b1;
    step("flush");
    chk("flush_valid", 32'(out_valid), 32'd0);
    chk("flush_ready", 32'(in_ready), 32'd1);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) step("post_flush");

    // random traffic with frequent forwarding hits
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 29) == 0);
      set_instr(6'($urandom_range(0, 8)), 5'($urandom), 5'($urandom_range(0, 3)),
                5'($urandom_range(0, 3)), $urandom, $urandom);
      mem_wen = 1'($urandom); mem_waddr = 5'($urandom_range(0, 3)); mem_wdata = $urandom;
      wb_wen  = 1'($urandom); wb_waddr  = 5'($urandom_range(0, 3)); wb_wdata  = $urandom;
      step("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
